key_voice_scheduler: RTL and testbench

Polyphony scheduler between the debounced keyboard inputs and the tone generators. It allows 13 piano keys to share a smaller pool of square-wave voices. The block scans the key vector, assigns each newly pressed key to a free voice and frees the voice on release. For each assigned voice it computes the half-period count, note constant divided by 2*scale, with a sequential divider and publishes it to that voice's generator.

---
 rtl/key_voice_scheduler.sv | 278 +++++++++++++++++++++++++++
 tb/tb_key_voice_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_voice_scheduler.sv
// key_voice_scheduler
// Shares a small pool of square-wave voices among 13 keyboard keys. A scan
// walks the synchronized key vector one key per cycle. It allocates free
// voices to new presses and frees voices on release. Each voice's half-period
// (note constant / 2*scale) comes from a bit-serial restoring divider.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when all are busy).
module key_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [12:0]                      KEYBOARD,
    input  logic [2:0]                       scale,
    output logic [NUM_VOICES-1:0][CNT_W-1:0] voice_period,
    output logic [NUM_VOICES-1:0][3:0]       voice_key,
    output logic [NUM_VOICES-1:0]            voice_active,
    output logic [NUM_VOICES-1:0]            voice_update,
    output logic                             busy
);
    localparam int CNT_IW = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {SCAN, DIV, WRITE} state_t;

    function automatic logic [17:0] note_const(input logic [3:0] k);
        case (k)
            4'd0:    note_const = 18'd191113;
            4'd1:    note_const = 18'd180387;
            4'd2:    note_const = 18'd170262;
            4'd3:    note_const = 18'd160706;
            4'd4:    note_const = 18'd151686;
            4'd5:    note_const = 18'd143173;
            4'd6:    note_const = 18'd135137;
            4'd7:    note_const = 18'd127553;
            4'd8:    note_const = 18'd120394;
            4'd9:    note_const = 18'd113636;
            4'd10:   note_const = 18'd107258;
            4'd11:   note_const = 18'd101238;
            4'd12:   note_const = 18'd95556;
            default: note_const = 18'd0;
        endcase
    endfunction

    // A scale of 0 behaves as 1 so the divisor is never zero
    function automatic logic [2:0] eff_scale(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

    state_t                   state, state_next;
    logic [12:0]              key_p0, key_p1;
    logic [2:0]               scale_p0, scale_p1;
    logic [3:0]               idx;
    logic [12:0]              assigned;
    logic [12:0][2:0]         owner;
    logic [2:0]               scale_lat;
    logic                     refresh;
    logic [CNT_IW-1:0]        cnt;
    logic [2:0]               tgt;
    logic [CNT_W-1:0]         dq;
    logic [3:0]               rem;
    logic [3:0]               divisor;
    logic [4:0]               rem_shift;

    logic                     key_now, asg_now, locked_now;
    logic                     free_found, alloc_ok;
    logic [2:0]               free_v, alloc_v, target_v;
    logic                     start_div, do_release, advance;

    assign key_now   = key_p1[idx];
    assign asg_now   = assigned[idx];
    assign target_v  = asg_now ? owner[idx] : alloc_v;
    assign rem_shift = {rem, dq[CNT_W-1]};
    assign busy      = (state == DIV) || (state == WRITE);

    // Lowest-index inactive voice
    always_comb begin
        free_found = 1'b0;
        free_v     = 3'd0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_found = 1'b1;
                free_v     = 3'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    function automatic logic [2:0] sat_inc(input logic [2:0] a);
        return (a == 3'd7) ? a : a + 3'd1;
    endfunction

    logic [NUM_VOICES-1:0][2:0] age;
    logic [12:0]                locked;
    logic [2:0]                 oldest_v, oldest_age;
    logic                       start_alloc, steal_now;

    assign alloc_ok    = 1'b1;
    assign locked_now  = locked[idx];
    assign alloc_v     = free_found ? free_v : oldest_v;
    assign start_alloc = start_div && !asg_now;
    assign steal_now   = start_alloc && !free_found;

    // Oldest voice; strict compare keeps ties on the lowest index
    always_comb begin
        oldest_v   = 3'd0;
        oldest_age = age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v] > oldest_age) begin
                oldest_v   = 3'(v);
                oldest_age = age[v];
            end
        end
    end

    // Voice ages and the lock that keeps a stolen, still-held key silent
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age    <= '0;
            locked <= '0;
        end else begin
            if (start_alloc) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (3'(v) == alloc_v)  age[v] <= 3'd0;
                    else if (voice_active[v]) age[v] <= sat_inc(age[v]);
                end
            end
            if (steal_now) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (3'(v) == alloc_v) locked[voice_key[v]] <= 1'b1;
            end
            if (state == SCAN && !key_now) locked[idx] <= 1'b0;
        end
    end
`else
    assign alloc_ok   = free_found;
    assign locked_now = 1'b0;
    assign alloc_v    = free_v;
`endif

    // Two-flop synchronizers for the asynchronous key vector and scale
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_p0   <= '0;
            key_p1   <= '0;
            scale_p0 <= '0;
            scale_p1 <= '0;
        end else begin
            key_p0   <= KEYBOARD;
            key_p1   <= key_p0;
            scale_p0 <= scale;
            scale_p1 <= scale_p0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SCAN;
        else          state <= state_next;
    end

    // FSM next state and per-cycle scan decisions
    always_comb begin
        state_next = state;
        start_div  = 1'b0;
        do_release = 1'b0;
        advance    = 1'b0;
        case (state)
            SCAN: begin
                if (key_now && !asg_now && !locked_now && alloc_ok) begin
                    start_div  = 1'b1;
                    state_next = DIV;
                end else if (!key_now && asg_now) begin
                    do_release = 1'b1;
                    advance    = 1'b1;
                end else if (key_now && asg_now && refresh) begin
                    start_div  = 1'b1;
                    state_next = DIV;
                end else begin
                    advance = 1'b1;
                end
            end
            DIV:     if (cnt == CNT_IW'(CNT_W - 1)) state_next = WRITE;
            WRITE: begin
                advance    = 1'b1;
                state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    // Scan index, iteration counter and scale-change refresh tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= 4'd0;
            cnt       <= '0;
            scale_lat <= 3'd1;
            refresh   <= 1'b0;
        end else begin
            if (start_div)          cnt <= '0;
            else if (state == DIV)  cnt <= cnt + 1'b1;
            if (advance) begin
                if (idx == 4'd12) begin
                    idx <= 4'd0;
                    if (eff_scale(scale_p1) != scale_lat) begin
                        scale_lat <= eff_scale(scale_p1);
                        refresh   <= 1'b1;
                    end else begin
                        refresh <= 1'b0;
                    end
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    // Restoring divider: dividend shifts out of dq as quotient bits shift in
    always_ff @(posedge clk) begin
        if (start_div) begin
            dq      <= CNT_W'(note_const(idx));
            rem     <= 4'd0;
            divisor <= {eff_scale(scale_p1), 1'b0};
            tgt     <= target_v;
        end else if (state == DIV) begin
            if (rem_shift >= {1'b0, divisor}) begin
                rem <= 4'(rem_shift - {1'b0, divisor});
                dq  <= {dq[CNT_W-2:0], 1'b1};
            end else begin
                rem <= rem_shift[3:0];
                dq  <= {dq[CNT_W-2:0], 1'b0};
            end
        end
    end

    // Voice outputs and key ownership: release clears, WRITE publishes, steal evicts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            voice_period <= '0;
            voice_key    <= '0;
            voice_active <= '0;
            voice_update <= '0;
            assigned     <= '0;
            owner        <= '0;
        end else begin
            voice_update <= '0;
            if (do_release) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (3'(v) == owner[idx]) begin
                        voice_period[v] <= '0;
                        voice_key[v]    <= 4'd0;
                        voice_active[v] <= 1'b0;
                        voice_update[v] <= 1'b1;
                    end
                end
                assigned[idx] <= 1'b0;
            end
            if (state == WRITE) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (3'(v) == tgt) begin
                        voice_period[v] <= dq;
                        voice_key[v]    <= idx;
                        voice_active[v] <= 1'b1;
                        voice_update[v] <= 1'b1;
                    end
                end
                assigned[idx] <= 1'b1;
                owner[idx]    <= tgt;
            end
`ifdef VOICE_STEAL_EN
            if (steal_now) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    if (3'(v) == alloc_v) assigned[voice_key[v]] <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_voice_scheduler.sv
// tb_key_voice_scheduler
// Directed test-plan steps followed by random press/release/scale events,
// each compared against an event-level polyphony model after the scan settles.
`timescale 1ns/1ps
module tb_key_voice_scheduler;
    localparam int NV     = 4;
    localparam int CW     = 32;
    localparam int SETTLE = 500;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [12:0]              KEYBOARD;
    logic [2:0]               scale;
    logic [NV-1:0][CW-1:0]    voice_period;
    logic [NV-1:0][3:0]       voice_key;
    logic [NV-1:0]            voice_active;
    logic [NV-1:0]            voice_update;
    logic                     busy;

    key_voice_scheduler #(.NUM_VOICES(NV), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .KEYBOARD(KEYBOARD), .scale(scale),
        .voice_period(voice_period), .voice_key(voice_key),
        .voice_active(voice_active), .voice_update(voice_update), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse bookkeeping sampled on the falling edge
    int            upd_total  = 0;
    bit            upd_multi  = 1'b0;
    bit            upd_repeat = 1'b0;
    logic [NV-1:0] upd_prev   = '0;
    always @(negedge clk) begin
        upd_total <= upd_total + $countones(voice_update);
        if ($countones(voice_update) > 1) upd_multi <= 1'b1;
        if ((voice_update & upd_prev) != '0) upd_repeat <= 1'b1;
        upd_prev <= voice_update;
    end

    // Reference model
    int     NOTE [13] = '{191113, 180387, 170262, 160706, 151686, 143173, 135137,
                          127553, 120394, 113636, 107258, 101238, 95556};
    int     m_owner   [13];
    bit     m_pressed [13];
    bit     m_locked  [13];
    bit     m_active  [NV];
    int     m_key     [NV];
    longint m_period  [NV];
    int     m_age     [NV];
    int     m_scale_eff;
    int     m_scale;
    int     exp_pulses;

    function automatic int eff(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic longint half_period(input int k, input int s);
        return longint'(NOTE[k]) / (2 * eff(s));
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 13; k++) begin
            m_owner[k]  = -1;
            m_locked[k] = 1'b0;
        end
        for (int v = 0; v < NV; v++) begin
            m_active[v] = 1'b0; m_key[v] = 0; m_period[v] = 0; m_age[v] = 0;
        end
        m_scale_eff = eff(m_scale);
    endtask

    task automatic m_alloc(input int k, input int v);
        for (int u = 0; u < NV; u++)
            if (u != v && m_active[u] && m_age[u] < 7) m_age[u]++;
        m_age[v]    = 0;
        m_active[v] = 1'b1;
        m_key[v]    = k;
        m_period[v] = half_period(k, m_scale);
        m_owner[k]  = v;
        exp_pulses++;
    endtask

    task automatic m_press(input int k);
        int v = -1;
        m_pressed[k] = 1'b1;
        for (int u = NV - 1; u >= 0; u--) if (!m_active[u]) v = u;
`ifdef VOICE_STEAL_EN
        if (v < 0) begin
            v = 0;
            for (int u = 1; u < NV; u++) if (m_age[u] > m_age[v]) v = u;
            m_owner[m_key[v]]  = -1;
            m_locked[m_key[v]] = 1'b1;
        end
`endif
        if (v >= 0) m_alloc(k, v);
    endtask

    task automatic m_release(input int k);
        int v = m_owner[k];
        m_pressed[k] = 1'b0;
        m_locked[k]  = 1'b0;
        if (v >= 0) begin
            m_owner[k]  = -1;
            m_active[v] = 1'b0; m_key[v] = 0; m_period[v] = 0;
            exp_pulses++;
            // the freed voice goes to the first waiting key the scan reaches
            for (int i = 1; i < 13; i++) begin
                int j = (k + i) % 13;
                if (m_pressed[j] && m_owner[j] < 0 && !m_locked[j]) begin
                    m_alloc(j, v);
                    break;
                end
            end
        end
    endtask

    task automatic m_set_scale(input int s);
        m_scale = s;
        if (eff(s) != m_scale_eff) begin
            m_scale_eff = eff(s);
            for (int v = 0; v < NV; v++) begin
                if (m_active[v]) begin
                    m_period[v] = half_period(m_key[v], s);
                    exp_pulses++;
                end
            end
        end
    endtask

    task automatic check_voices(input string tag);
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("%s_period%0d", tag, v), longint'(voice_period[v]), m_period[v]);
            chk($sformatf("%s_key%0d", tag, v), longint'(voice_key[v]), longint'(m_key[v]));
            chk($sformatf("%s_active%0d", tag, v), longint'(voice_active[v]), longint'(m_active[v]));
        end
        chk({tag, "_update_onehot"}, longint'(upd_multi), 0);
        chk({tag, "_update_single_cycle"}, longint'(upd_repeat), 0);
    endtask

    task automatic check_zero(input string tag);
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("%s_period%0d", tag, v), longint'(voice_period[v]), 0);
            chk($sformatf("%s_key%0d", tag, v), longint'(voice_key[v]), 0);
        end
        chk({tag, "_active"}, longint'(voice_active), 0);
        chk({tag, "_update"}, longint'(voice_update), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
    endtask

    task automatic settle_from(input int start_cnt, input string tag);
        repeat (SETTLE) @(negedge clk);
        chk({tag, "_pulses"}, longint'(upd_total - start_cnt), longint'(exp_pulses));
        check_voices(tag);
    endtask

    // kind 0 = press, 1 = release, 2 = scale change
    task automatic ev(input int kind, input int arg, input string tag);
        int start_cnt;
        @(negedge clk);
        start_cnt  = upd_total;
        exp_pulses = 0;
        case (kind)
            0:       begin KEYBOARD[arg] = 1'b1; m_press(arg);   end
            1:       begin KEYBOARD[arg] = 1'b0; m_release(arg); end
            default: begin scale = 3'(arg);      m_set_scale(arg); end
        endcase
        settle_from(start_cnt, tag);
    endtask

    task automatic release_all();
        for (int k = 0; k < 13; k++)
            if (m_pressed[k]) ev(1, k, $sformatf("relall_k%0d", k));
    endtask

    initial begin
        int start_cnt, n, k1, k2;
        reset_n  = 1'b0;
        KEYBOARD = '0;
        scale    = 3'd1;
        m_scale  = 1;
        for (int k = 0; k < 13; k++) m_pressed[k] = 1'b0;
        m_clear();

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (50) @(negedge clk);

        // key 0 at scale 1, with allocation latency
        @(negedge clk);
        start_cnt = upd_total; exp_pulses = 0;
        KEYBOARD[0] = 1'b1; m_press(0);
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        chk("busy_seen", longint'(busy), 1);
        n = 0;
        while (voice_update == '0 && n < 100) begin @(negedge clk); n++; end
        chk("alloc_latency", longint'(n), 33);
        settle_from(start_cnt, "k0_s1");
        chk("k0_s1_const", longint'(voice_period[0]), 95556);
        ev(1, 0, "k0_off");

        // key 12 at scale 2, then refresh to scale 3
        ev(2, 2, "s2");
        ev(0, 12, "k12_s2");
        chk("k12_s2_const", longint'(voice_period[0]), 23889);
        ev(2, 3, "s3_refresh");
        chk("k12_s3_const", longint'(voice_period[0]), 15926);
        ev(1, 12, "k12_off");

        // keys 0 and 3 at scale 3, release key 0
        ev(0, 0, "k0_s3");
        ev(0, 3, "k3_s3");
        chk("k0_s3_const", longint'(voice_period[0]), 31852);
        chk("k3_s3_const", longint'(voice_period[1]), 26784);
        @(negedge clk);
        start_cnt = upd_total; exp_pulses = 0;
        KEYBOARD[0] = 1'b0; m_release(0);
        n = 0;
        while (voice_update[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("rel_pulse_seen", longint'(voice_update[0]), 1);
        chk("rel_period_cleared", longint'(voice_period[0]), 0);
        chk("rel_inactive", longint'(voice_active[0]), 0);
        chk("rel_other_kept", longint'(voice_period[1]), 26784);
        settle_from(start_cnt, "rel_k0");
        ev(1, 3, "k3_off");

        // scale 0 behaves as scale 1
        ev(2, 0, "s0");
        ev(0, 5, "k5_s0");
        chk("k5_s0_const", longint'(voice_period[0]), 71586);
        ev(1, 5, "k5_off");

        // five keys on four voices
        ev(2, 1, "s1");
        for (int k = 0; k < 5; k++) ev(0, k, $sformatf("seq_k%0d", k));
`ifdef VOICE_STEAL_EN
        chk("steal_key", longint'(voice_key[0]), 4);
        chk("steal_period", longint'(voice_period[0]), 75843);
`else
        chk("nosteal_k4_waits", longint'(voice_key[0]), 0);
        ev(1, 1, "seq_k1_off");
        chk("nosteal_k4_takes_v1", longint'(voice_key[1]), 4);
        chk("nosteal_k4_period", longint'(voice_period[1]), 75843);
`endif
        release_all();

        // random press / release / scale traffic
        for (int i = 0; i < 30; i++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 2) begin
                ev(2, int'($urandom_range(0, 7)), $sformatf("rnd%0d_scale", i));
            end else begin
                int k = int'($urandom_range(0, 12));
                if (m_pressed[k]) ev(1, k, $sformatf("rnd%0d_rel%0d", i, k));
                else              ev(0, k, $sformatf("rnd%0d_prs%0d", i, k));
            end
        end
        release_all();

        // reset in the middle of a division
        k1 = int'($urandom_range(2, 7));
        k2 = int'($urandom_range(8, 12));
        @(negedge clk);
        KEYBOARD[k1] = 1'b1; KEYBOARD[k2] = 1'b1;
        n = 0;
        while (!busy && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("div_busy_before_reset", longint'(busy), 1);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        m_pressed[k1] = 1'b0; m_pressed[k2] = 1'b0;
        m_clear();
        m_press(k1);
        m_press(k2);
        repeat (SETTLE) @(negedge clk);
        check_voices("post_reset");
        chk("post_reset_v0_key", longint'(voice_key[0]), longint'(k1));
        chk("post_reset_v1_key", longint'(voice_key[1]), longint'(k2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
